// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if
//   Groups the vertical-sync input, the mode/request handshake and the
//   character-select outputs of the frame scheduler.
//   Ports (slave = scheduler side):
//     vsync      in   active-low vertical sync
//     mode_auto  in   1 = slideshow, 0 = manual hold
//     next_req   in   level request to advance the character
//     next_ack   out  one-cycle acknowledge of an accepted request
//     char_sel   out  CHAR_W character index for the plotter
//     frame_tick out  one-cycle pulse at the start of vertical sync
interface frame_scheduler_if #(
    parameter int CHAR_W = 1
);
    logic              vsync;
    logic              mode_auto;
    logic              next_req;
    logic              next_ack;
    logic [CHAR_W-1:0] char_sel;
    logic              frame_tick;

    modport master (
        output vsync, mode_auto, next_req,
        input  next_ack, char_sel, frame_tick
    );

    modport slave (
        input  vsync, mode_auto, next_req,
        output next_ack, char_sel, frame_tick
    );
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Chooses which character the plotter draws. In manual mode the character
//   only advances on request; in auto mode it also advances every
//   FRAMES_PER_CHAR frames. Changes are applied only during vertical
//   blanking, two cycles after the vsync falling edge is sampled.
//   Ports:
//     clk  in   pixel clock
//     rst  in   synchronous active-high reset
//     bus  slave modport of frame_scheduler_if (vsync, mode_auto, next_req,
//          next_ack, char_sel, frame_tick)
module frame_scheduler #(
    parameter int NUM_CHARS       = 2,
    parameter int CHAR_W          = 1,
    parameter int FRAMES_PER_CHAR = 60
) (
    input  logic                clk,
    input  logic                rst,
    frame_scheduler_if.slave    bus
);
    localparam int CNT_W = (FRAMES_PER_CHAR > 1) ? $clog2(FRAMES_PER_CHAR) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAMES_PER_CHAR - 1);
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {MANUAL, AUTO, SWAP} state_t;

    state_t              state_reg, state_next;
    logic                vsync_q_reg;
    logic                armed_reg;
    logic                frame_tick_reg;
    logic                next_req_q_reg;
    logic                pending_reg;
    logic                next_ack_reg;
    logic [CNT_W-1:0]    frame_cnt_reg;
    logic [CHAR_W-1:0]   char_sel_reg;

    logic req_edge;
    logic cnt_wrap;
    logic advance_due;

    assign req_edge    = bus.next_req & ~next_req_q_reg;
    assign cnt_wrap    = (frame_cnt_reg == CNT_LAST);
    assign advance_due = pending_reg | ((state_reg == AUTO) & cnt_wrap);

    assign bus.next_ack   = next_ack_reg;
    assign bus.char_sel   = char_sel_reg;
    assign bus.frame_tick = frame_tick_reg;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= MANUAL;
        else     state_reg <= state_next;
    end

    // An advance due at a frame tick wins over a simultaneous mode change;
    // SWAP always lasts exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MANUAL: begin
                if (frame_tick_reg && advance_due) state_next = SWAP;
                else if (bus.mode_auto)            state_next = AUTO;
            end
            AUTO: begin
                if (frame_tick_reg && advance_due) state_next = SWAP;
                else if (!bus.mode_auto)           state_next = MANUAL;
            end
            SWAP:    state_next = bus.mode_auto ? AUTO : MANUAL;
            default: state_next = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q_reg    <= 1'b1;
            armed_reg      <= 1'b0;
            frame_tick_reg <= 1'b0;
            next_req_q_reg <= 1'b0;
            pending_reg    <= 1'b0;
            next_ack_reg   <= 1'b0;
            frame_cnt_reg  <= '0;
            char_sel_reg   <= '0;
        end else begin
            vsync_q_reg <= bus.vsync;
            // vsync_q is only trusted once a real high level has been seen,
            // so a vsync already low at reset release does not tick.
            armed_reg      <= armed_reg | bus.vsync;
            frame_tick_reg <= armed_reg & vsync_q_reg & ~bus.vsync;

            next_req_q_reg <= bus.next_req;
            next_ack_reg   <= 1'b0;
            // During SWAP the old request is being consumed, so a fresh edge
            // is accepted and carried into the next frame.
            if (req_edge && (!pending_reg || state_reg == SWAP)) begin
                pending_reg  <= 1'b1;
                next_ack_reg <= 1'b1;
            end else if (state_reg == SWAP) begin
                pending_reg <= 1'b0;
            end

            if (state_reg == AUTO) begin
                if (frame_tick_reg)
                    frame_cnt_reg <= cnt_wrap ? '0 : frame_cnt_reg + 1'b1;
            end else begin
                frame_cnt_reg <= '0;
            end

            if (state_reg == SWAP)
                char_sel_reg <= (char_sel_reg == CHAR_LAST) ? '0 : char_sel_reg + 1'b1;
        end
    end
endmodule
